mdu_ctrl: RTL and testbench

//  Sequencer for the MIPS multiply/divide unit. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/mdu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS multiply/divide sequencer owning the architectural HI/LO.
// Multiplies complete after MUL_CYCLES cycles; divides use a 32-step radix-2
// restoring divider followed by a sign-fix cycle.
module mdu_ctrl #(
    parameter int unsigned MUL_CYCLES     = 2,
    parameter bit          DIV_EARLY_ZERO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] a_q;      // multiplier, or dividend shifting out / quotient shifting in
    logic [31:0] b_q;      // multiplicand, or divisor magnitude
    logic [31:0] rem_q;    // partial remainder; holds raw rs on divide by zero
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        sgn_q;
    logic        dz_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        done_q;

    op_t         op;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        rem_ge;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Operand conditioning, product, one divider step and final sign fix-up.
    always_comb begin
        op      = op_t'(op_i);
        rs_neg  = (op == OP_DIV) && rs_i[31];
        rt_neg  = (op == OP_DIV) && rt_i[31];
        rs_mag  = rs_neg ? (~rs_i + 32'd1) : rs_i;
        rt_mag  = rt_neg ? (~rt_i + 32'd1) : rt_i;
        ext_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod    = ext_a * ext_b;
        rem_sh  = {rem_q, a_q[31]};
        rem_ge  = (rem_sh >= {1'b0, b_q});
        // When rem_sh >= b the difference is below b, so 32 bits suffice.
        rem_sub = rem_sh[31:0] - b_q;
        q_fix   = qneg_q ? (~a_q + 32'd1) : a_q;
        r_fix   = rneg_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Sequencer: accept, multiply countdown, divide iterations, fix-up and HI/LO writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (op_valid_i) begin
                            case (op)
                                OP_MTHI: hi_q <= rs_i;
                                OP_MTLO: lo_q <= rs_i;
                                OP_MULT, OP_MULTU: begin
                                    a_q     <= rs_i;
                                    b_q     <= rt_i;
                                    sgn_q   <= (op == OP_MULT);
                                    cnt_q   <= MUL_CNT_INIT;
                                    state_q <= S_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    a_q     <= rs_mag;
                                    b_q     <= rt_mag;
                                    dz_q    <= (rt_i == '0);
                                    rem_q   <= (rt_i == '0) ? rs_i : '0;
                                    qneg_q  <= rs_neg ^ rt_neg;
                                    rneg_q  <= rs_neg;
                                    cnt_q   <= DIV_CNT_INIT;
                                    state_q <= ((rt_i == '0) && DIV_EARLY_ZERO) ? S_FIX : S_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        if (cnt_q == '0) begin
                            hi_q    <= prod[63:32];
                            lo_q    <= prod[31:0];
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    S_DIV: begin
                        // A zero divisor only burns cycles; rem_q keeps the raw dividend.
                        if (!dz_q) begin
                            a_q   <= {a_q[30:0], rem_ge};
                            rem_q <= rem_ge ? rem_sub : rem_sh[31:0];
                        end
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    S_FIX: begin
                        if (dz_q) begin
                            hi_q <= rem_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table vectors, hand-written flush/reset/busy sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int unsigned MULC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
        logic        done;
    } vec_t;

    vec_t tbl[14];

    mdu_ctrl #(.MUL_CYCLES(MULC), .DIV_EARLY_ZERO(1'b1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .op_valid_i(op_valid),
        .op_i      (op),
        .rs_i      (rs),
        .rt_i      (rt),
        .flush_i   (flush),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural result of one op from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output int eb, output logic ed);
        logic [63:0] p;
        longint      sa, sb, q, r;
        eh = m_hi; el = m_lo; eb = 0; ed = 1'b0;
        case (o)
            3'd1: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32]; el = p[31:0]; eb = MULC; ed = 1'b1;
            end
            3'd2: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32]; el = p[31:0]; eb = MULC; ed = 1'b1;
            end
            3'd3, 3'd4: begin
                ed = 1'b1;
                if (b == 0) begin
                    el = 32'hFFFFFFFF; eh = a; eb = 1;
                end else begin
                    eb = 33;
                    if (o == 3'd3) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        q  = sa / sb;
                        r  = sa % sb;
                        el = q[31:0]; eh = r[31:0];
                    end else begin
                        el = a / b; eh = a % b;
                    end
                end
            end
            3'd5: eh = a;
            3'd6: el = a;
            default: ;
        endcase
    endtask

    task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
    endtask

    // Issue one op at a negedge and follow it to completion; returns at the negedge where busy is low.
    task automatic apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int eb, input logic ed, input string tag);
        int   n;
        logic early;
        n = 0; early = 1'b0;
        start(o, a, b);
        while (busy === 1'b1 && n < 100) begin
            if (done !== 1'b0) early = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, n, eb);
        chk({tag, " done_in_busy"}, {31'b0, early}, 32'd0);
        chk({tag, " done"}, {31'b0, done}, {31'b0, ed});
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        int          eb, n;
        logic        ed;
        logic [2:0]  o;

        tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2,  1'b1};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2,  1'b1};
        tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1};
        tbl[3]  = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b1};
        tbl[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
        tbl[5]  = '{3'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1,  1'b1};
        tbl[6]  = '{3'd3, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 32'hFFFFFFFF, 1,  1'b1};
        tbl[7]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b1};
        tbl[8]  = '{3'd5, 32'h0000DEAD, 32'd0,        32'h0000DEAD, 32'hFFFFFFFD, 0,  1'b0};
        tbl[9]  = '{3'd6, 32'h0000BEEF, 32'd0,        32'h0000DEAD, 32'h0000BEEF, 0,  1'b0};
        tbl[10] = '{3'd0, 32'h00001234, 32'd9,        32'h0000DEAD, 32'h0000BEEF, 0,  1'b0};
        tbl[11] = '{3'd7, 32'h00001234, 32'd9,        32'h0000DEAD, 32'h0000BEEF, 0,  1'b0};
        tbl[12] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2,  1'b1};
        tbl[13] = '{3'd3, 32'h80000000, 32'd3,        32'hFFFFFFFE, 32'hD5555556, 33, 1'b1};

        rst = 1'b1; op_valid = 1'b0; op = 3'd0; rs = '0; rt = '0; flush = 1'b0;
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo,
                  tbl[i].busy, tbl[i].done, $sformatf("vec%0d", i));
        end

        // Flush on busy cycle 10 of a divide.
        apply(3'd5, 32'h1234, 32'd0, 32'h1234, m_lo, 0, 1'b0, "mthi_pre");
        start(3'd3, 32'd9, 32'd2);
        repeat (9) @(negedge clk);
        chk("flush_div busy_c10", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_div busy", {31'b0, busy}, 32'd0);
        chk("flush_div done", {31'b0, done}, 32'd0);
        chk("flush_div hi", hi, 32'h1234);
        chk("flush_div lo", lo, m_lo);
        @(negedge clk);
        chk("flush_div done_late", {31'b0, done}, 32'd0);

        // Flush on the multiply's final (cnt==0) cycle.
        start(3'd2, 32'd5, 32'd6);
        @(negedge clk);
        chk("flush_mul busy_last", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mul busy", {31'b0, busy}, 32'd0);
        chk("flush_mul done", {31'b0, done}, 32'd0);
        chk("flush_mul hi", hi, m_hi);
        chk("flush_mul lo", lo, m_lo);

        // Flush during the early divide-by-zero FIX cycle.
        start(3'd4, 32'd9, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_fix done", {31'b0, done}, 32'd0);
        chk("flush_fix hi", hi, m_hi);
        chk("flush_fix lo", lo, m_lo);

        // op_valid together with flush in IDLE is not accepted.
        op_valid = 1'b1; op = 3'd5; rs = 32'h5555; flush = 1'b1;
        @(negedge clk);
        op = 3'd1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0; op = 3'd0;
        chk("flush_accept hi", hi, m_hi);
        chk("flush_accept busy", {31'b0, busy}, 32'd0);

        // Ops offered while busy are ignored.
        start(3'd2, 32'd3, 32'd4);
        op_valid = 1'b1; op = 3'd6; rs = 32'h7777;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            op_valid = 1'b0;
        end
        chk("busy_mtlo cycles", n, MULC);
        chk("busy_mtlo hi", hi, 32'd0);
        chk("busy_mtlo lo", lo, 32'd12);
        start(3'd4, 32'd100, 32'd7);
        op_valid = 1'b1; op = 3'd1; rs = 32'd2; rt = 32'd2;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            op_valid = 1'b0;
        end
        chk("busy_mult cycles", n, 32'd33);
        chk("busy_mult done", {31'b0, done}, 32'd1);
        chk("busy_mult hi", hi, 32'd2);
        chk("busy_mult lo", lo, 32'd14);
        m_hi = 32'd2; m_lo = 32'd14;

        // Asynchronous reset in the middle of a divide.
        start(3'd3, 32'hFFFFFF00, 32'd5);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid busy", {31'b0, busy}, 32'd0);
        chk("rst_mid hi", hi, 32'd0);
        chk("rst_mid lo", lo, 32'd0);
        chk("rst_mid done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            model(o, a, b, eh, el, eb, ed);
            apply(o, a, b, eh, el, eb, ed, $sformatf("rnd%0d op%0d", i, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
